// File: rtl/angle_sweeper_pkg.sv
// Shared definitions for the angle sweeper: sweep mode encodings, default
// angle constants and a counter-width helper.
package angle_sweeper_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'b00,
    MODE_WRAP     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_CASCADE  = 2'b11
  } mode_e;

  localparam int DEF_ANGLE_W   = 11;
  localparam int DEF_MAX_ANGLE = 359;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/angle_sweeper_axis.sv
// Single-axis angle stepper. It exposes its limit condition regardless of
// enable, so the top can build the cascade carry chain without a loop.
module angle_axis
  import angle_sweeper_pkg::*;
#(
  parameter int ANGLE_W   = DEF_ANGLE_W,
  parameter int MAX_ANGLE = DEF_MAX_ANGLE,
  parameter int STEP      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  mode_e              mode,
  input  logic               forward,
  output logic [ANGLE_W-1:0] angle,
  output logic               limit
);

  localparam logic [ANGLE_W:0] MAX_X  = (ANGLE_W + 1)'(MAX_ANGLE);
  localparam logic [ANGLE_W:0] STEP_X = (ANGLE_W + 1)'(STEP);

  // One spare MSB keeps angle+STEP from overflowing before the limit compare.
  logic [ANGLE_W:0] angle_q, angle_d;
  logic [ANGLE_W:0] up_x, dn_x, next_x;
  logic             dir_up_q, dir_up_d;
  logic             dir_next;

  always_comb begin
    up_x     = angle_q + STEP_X;
    dn_x     = angle_q - STEP_X;
    limit    = 1'b0;
    next_x   = angle_q;
    dir_next = dir_up_q;
    if (mode == MODE_PINGPONG) begin
      if (dir_up_q) begin
        limit    = (up_x >= MAX_X);
        next_x   = limit ? MAX_X : up_x;
        dir_next = ~limit;
      end else begin
        limit    = (angle_q <= STEP_X);
        next_x   = limit ? '0 : dn_x;
        dir_next = limit;
      end
    end else if (forward) begin
      limit  = (up_x > MAX_X);
      next_x = limit ? '0 : up_x;
    end else begin
      limit  = (angle_q < STEP_X);
      next_x = limit ? MAX_X : dn_x;
    end

    angle_d  = angle_q;
    dir_up_d = dir_up_q;
    if (en) begin
      angle_d  = next_x;
      dir_up_d = dir_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      angle_q  <= '0;
      dir_up_q <= 1'b1;
    end else begin
      angle_q  <= angle_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign angle = angle_q[ANGLE_W-1:0];

endmodule

// File: rtl/angle_sweeper.sv
// Multi-axis angle sweeper: shared step prescaler, per-axis steppers and a
// frame-synchronous output shadow so displayed angles never change mid-frame.
module angle_sweeper
  import angle_sweeper_pkg::*;
#(
  parameter int N_AXES    = 2,
  parameter int ANGLE_W   = DEF_ANGLE_W,
  parameter int PRESCALE  = 1000000,
  parameter int MAX_ANGLE = DEF_MAX_ANGLE,
  parameter int STEP      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode,
  input  logic                      forward,
  input  logic                      frame_sync,
  output logic [N_AXES*ANGLE_W-1:0] angle_out,
  output logic [N_AXES-1:0]         wrap_pulse,
  output logic                      tick
);

  localparam int               CNT_W    = cnt_width(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  mode_e                     mode_s;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [N_AXES-1:0]         axis_en, axis_limit;
  logic [N_AXES-1:0]         wrap_q, wrap_d;
  logic [N_AXES*ANGLE_W-1:0] angles;
  logic [N_AXES*ANGLE_W-1:0] angle_out_q, angle_out_d;

  assign mode_s = mode_e'(mode);

  always_comb begin
    tick        = (cnt_q == CNT_LAST);
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    wrap_d      = axis_en & axis_limit;
    // Shadow captures pre-edge working angles, so a coincident tick is not seen.
    angle_out_d = frame_sync ? angles : angle_out_q;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_AXES; gi++) begin : g_axis
      if (gi == 0) begin : g_first
        assign axis_en[gi] = tick && (mode_s != MODE_HOLD);
      end else begin : g_rest
        // Odometer carry: every lower axis must roll over in this same tick.
        assign axis_en[gi] = tick &&
                             ((mode_s == MODE_WRAP) || (mode_s == MODE_PINGPONG) ||
                              ((mode_s == MODE_CASCADE) && (&axis_limit[gi-1:0])));
      end

      angle_axis #(
        .ANGLE_W  (ANGLE_W),
        .MAX_ANGLE(MAX_ANGLE),
        .STEP     (STEP)
      ) u_axis (
        .clk    (clk),
        .rst    (rst),
        .en     (axis_en[gi]),
        .mode   (mode_s),
        .forward(forward),
        .angle  (angles[gi*ANGLE_W +: ANGLE_W]),
        .limit  (axis_limit[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      wrap_q      <= '0;
      angle_out_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
      angle_out_q <= angle_out_d;
    end
  end

  assign angle_out  = angle_out_q;
  assign wrap_pulse = wrap_q;

endmodule
